serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//  Bit-serial two's-complement subtractor: computes D = A - B - Bin one bit per clock, LSB first.
//  It uses a single full-subtractor cell and a registered borrow.
//  This is the inverse-direction companion of the ripple adder datapath.
//  It is used by game logic (paddle/ball position deltas, score countdown) where area matters
//  more than latency. It sits between the game-state registers and the collision/score logic,
//  and uses a start/busy/done handshake.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (legal range 2..32)
// PORTS
//  clk    in   1      system clock, all state on rising edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only while idle
//  A      in   WIDTH  minuend, captured on accepted start
//  B      in   WIDTH  subtrahend, captured on accepted start
//  Bin    in   1      borrow in, captured on accepted start
//  busy   out  1      high while bits are being processed
//  done   out  1      one-cycle pulse: result valid
//  D      out  WIDTH  difference A-B-Bin (mod 2^WIDTH), held until next accepted start
//  Bout   out  1      borrow out (1 when unsigned A < B+Bin)
//  zero   out  1      D == 0
//  ovfl   out  1      signed overflow: sign(A) != sign(B) and sign(D) != sign(A)
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n).
//    Reset clears the state to IDLE.
//    Reset also forces busy=0, done=0, D=0, Bout=0, zero=0, ovfl=0, and clears the shift regs and bit counter.
//  - States: IDLE, SUB.
//    IDLE->SUB on start=1: load a_sr=A, b_sr=B, borrow=Bin, cnt=0, and latch sign bits A[W-1], B[W-1].
//    SUB: every clock, the cell takes a_sr[0], b_sr[0] and borrow:
//      d  = a^b^bor
//      bo = (~a&b) | (~(a^b)&bor)
//    Then a_sr/b_sr shift right, d shifts into the result MSB, borrow<=bo, cnt++.
//    SUB->IDLE on the clock where cnt==WIDTH-1 (the last bit). On that same edge, D, Bout, zero, ovfl
//    are updated and done is set.
//  - Latency: start high in cycle 0 -> busy high in cycles 1..WIDTH -> done high in cycle WIDTH+1 only.
//    D, Bout, zero and ovfl change only at that edge. They are stable from cycle WIDTH+1 until the next done.
//  - start while busy: ignored. No queueing, and captured operands are unaffected.
//  - start in the done cycle: accepted, because state is IDLE. busy rises next cycle, and D keeps the
//    old result until the new done.
//  - A/B/Bin changes after capture have no effect.
//  - Wrap-around: the result is modulo 2^WIDTH. For example, 0-1 gives all ones with Bout=1.
//  - rst_n asserted mid-operation: the operation is aborted immediately, no done pulse, outputs return
//    to reset values.
//  - cnt is sized $clog2(WIDTH), with no overflow possible.
// STRUCTURE
//  - Shared package pong_pkg: typedef enum logic {IDLE, SUB} sub_state_t.
//    The package also holds localparam SUB_W_DEFAULT = 8.
//  - One sub-module: full_sub.
//    Ports: A, B, Bin, D, Bout. It is purely combinational.
//    It is instantiated once, with the registered borrow fed back.
//  - No other hierarchy: the FSM, counter and shift regs live in serial_sub.
// TESTING (WIDTH=8)
//  - Reset mid-run: start A=8'h50, B=8'h20, Bin=0.
//    Assert rst_n=0 at cycle 4 -> busy=0, D=0 immediately, no done. Release, then idle.
//  - Basic: A=8'h50, B=8'h20, Bin=0 -> busy cycles 1..8.
//    In cycle 9: done=1, D=8'h30, Bout=0, zero=0, ovfl=0.
//  - Wrap/borrow: A=8'h00, B=8'h01, Bin=0 -> D=8'hFF, Bout=1, ovfl=0.
//    Also A=8'h05, B=8'h05, Bin=0 -> D=0, zero=1.
//  - Signed overflow and borrow-in: A=8'h80, B=8'h01, Bin=0 -> D=8'h7F, ovfl=1, Bout=0.
//    Also A=8'h10, B=8'h0F, Bin=1 -> D=0, zero=1.
//  - Handshake: pulse start in cycle 3 while busy -> ignored, a single done only.
//    Then start again in the done cycle with A=8'h09, B=8'h03 -> previous D held.
//    The new done comes exactly WIDTH+1 cycles later with D=8'h06.
//  - Random: 1000 random A/B/Bin compared against the reference model A-B-Bin.
//    Each check also verifies the done-to-done spacing is >= WIDTH+1.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and defaults for the game-logic arithmetic blocks
package pong_pkg;
  typedef enum logic {IDLE, SUB} sub_state_t;
  localparam int SUB_W_DEFAULT = 8;
endpackage

// File: rtl/full_sub.sv
// full_sub: single-bit combinational full subtractor cell
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial A-B-Bin, LSB first, one full-subtractor cell with registered borrow
import pong_pkg::*;
module serial_sub #(
  parameter int WIDTH = SUB_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             ovfl
);
  localparam int CW = $clog2(WIDTH);
  sub_state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_nx;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0] cnt;
  logic bor, sa, sb, d_bit, bo_bit, last;
  full_sub u_cell (.A(a_sr[0]), .B(b_sr[0]), .Bin(bor), .D(d_bit), .Bout(bo_bit));
  assign last = cnt == CW'(WIDTH - 1);
  // new bit enters at the MSB so after WIDTH shifts the word is in natural order
  assign r_nx = {d_bit, r_sr};
  assign busy = state == SUB;
  always_comb begin
    state_nx = (state == IDLE) ? (start ? SUB : IDLE) : (last ? IDLE : SUB);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      bor  <= 1'b0;
      cnt  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      done <= 1'b0;
      D    <= '0;
      Bout <= 1'b0;
      zero <= 1'b0;
      ovfl <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sr <= A;
        b_sr <= B;
        bor  <= Bin;
        cnt  <= '0;
        sa   <= A[WIDTH-1];
        sb   <= B[WIDTH-1];
      end else if (state == SUB) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= r_nx[WIDTH-1:1];
        bor  <= bo_bit;
        cnt  <= cnt + 1'b1;
        if (last) begin
          D    <= r_nx;
          Bout <= bo_bit;
          zero <= r_nx == '0;
          ovfl <= (sa != sb) && (d_bit != sa);
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8
module tb_serial_sub;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] d; logic bout; logic zero; logic ovfl;} exp_t;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic bin; logic [W-1:0] d; logic bo; logic z; logic o;} vec_t;
  logic clk = 1'b0, rst_n, start, Bin, busy, done, Bout, zero, ovfl;
  logic [W-1:0] A, B, D;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_fail = 0, n_push = 0, done_cnt = 0, cyc = 0, last_done = -1;
  vec_t vt[6] = '{
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1},
    '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}
  };
  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .zero(zero), .ovfl(ovfl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (last_done >= 0) chk("done_spacing", 32'((cyc - last_done) >= W + 1), 32'd1);
      last_done = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got D=%0h with empty scoreboard", D);
      end else begin
        mon_e = sb.pop_front();
        chk("result{D,Bout,zero,ovfl}", 32'({D, Bout, zero, ovfl}), 32'(mon_e));
      end
    end
  end
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    return {r[W-1:0], r[W], r[W-1:0] == '0, (a[W-1] != b[W-1]) && (r[W-1] != a[W-1])};
  endfunction
  task automatic push(input exp_t e);
    sb.push_back(e);
    n_push++;
  endtask
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a;
    B = b;
    Bin = bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom);
  endtask
  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
    end
    #1;
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rbin;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_outs", 32'({D, Bout, zero, ovfl}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_op(8'h50, 8'h20, 1'b0);
    push({8'h30, 1'b0, 1'b0, 1'b0});
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      chk("basic_busy", 32'(busy), 1);
      chk("basic_no_early_done", 32'(done), 0);
    end
    @(negedge clk);
    chk("basic_done_cycle", 32'(done), 1);
    chk("basic_idle_at_done", 32'(busy), 0);
    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      start_op(vt[i].a, vt[i].b, vt[i].bin);
      push({vt[i].d, vt[i].bo, vt[i].z, vt[i].o});
      wait_done(n_push);
    end
    start_op(8'h22, 8'h11, 1'b0);
    push({8'h11, 1'b0, 1'b0, 1'b0});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    A = 8'hFF;
    B = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("hs_done_cycle", 32'(done), 1);
    start_op(8'h09, 8'h03, 1'b0);
    push({8'h06, 1'b0, 1'b0, 1'b0});
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      chk("hs_busy", 32'(busy), 1);
      chk("hs_D_held", 32'(D), 32'h11);
    end
    @(negedge clk);
    chk("hs_new_done", 32'(done), 1);
    @(posedge clk);
    #1;
    chk("hs_done_count", 32'(done_cnt), 32'(n_push));
    start_op(8'h50, 8'h20, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_outs", 32'({D, Bout, zero, ovfl}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(busy) + int'(done);
    end
    chk("abort_stays_idle", 32'(seen), 0);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      start_op(ra, rb, rbin);
      push(model(ra, rb, rbin));
      wait_done(n_push);
    end
    chk("final_done_count", 32'(done_cnt), 32'(n_push));
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
